// File: rtl/conv_enc_pkg.sv
// Shared types, generator constants and the symbol function for the
// parametrised convolutional encoder.
package conv_enc_pkg;

  typedef enum logic {ST_DATA, ST_FLUSH} state_e;

  localparam logic [5:0]  G_K3_R12  = {3'b111, 3'b101};
  localparam logic [13:0] G_K7_R12  = {7'o171, 7'o133};
  localparam logic [3:0]  PUNCT_R23 = {2'b10, 2'b11};

  // w holds the K-bit window in its low bits, current bit at w[k-1].
  function automatic logic [3:0] conv_enc_sym(
    input logic [8:0]  w,
    input logic [35:0] g,
    input int          k,
    input int          n
  );
    logic [3:0] s;
    logic [8:0] gi;
    logic [8:0] km;
    s  = '0;
    km = 9'((36'd1 << k) - 36'd1);
    for (int i = 0; i < 4; i++) begin
      if (i < n) begin
        gi = 9'(g >> (i * k));
        s  = s | (4'(^(gi & w & km)) << i);
      end
    end
    return s;
  endfunction

endpackage

// File: rtl/conv_encoder_param_punct.sv
// Mod-P symbol counter with clear-on-last and puncture mask lookup.
// Used by conv_encoder_param only when CONV_ENC_PUNCT_EN is defined.
module conv_punct_idx
  import conv_enc_pkg::*;
#(
  parameter int N = 2,
  parameter int P = 2,
  parameter logic [N*P-1:0] PUNCT = PUNCT_R23
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         step,
  input  logic         last,
  input  logic         punct_on,
  output logic [N-1:0] mask
);

  localparam int IW = (P > 1) ? $clog2(P) : 1;

  logic [IW-1:0] idx;

  assign mask = punct_on ? N'(PUNCT >> (idx * N)) : '1;

  always_ff @(posedge clk) begin
    if (reset) begin
      idx <= '0;
    end else if (step) begin
      if (last || idx == IW'(P - 1))
        idx <= '0;
      else
        idx <= idx + IW'(1);
    end
  end

endmodule

// File: rtl/conv_encoder_param.sv
// Zero-terminated rate-1/N feed-forward convolutional encoder.
// Optional puncture mask output under CONV_ENC_PUNCT_EN.
module conv_encoder_param
  import conv_enc_pkg::*;
#(
  parameter int K = 3,
  parameter int N = 2,
  parameter logic [N*K-1:0] G = G_K3_R12
`ifdef CONV_ENC_PUNCT_EN
  ,
  parameter int P = 2,
  parameter logic [N*P-1:0] PUNCT = PUNCT_R23
`endif
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         in_data,
  input  logic         in_last,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_data,
  output logic         out_last
`ifdef CONV_ENC_PUNCT_EN
  ,
  input  logic         punct_on,
  output logic [N-1:0] out_mask
`endif
);

  localparam int SRW = (K > 1) ? K - 1 : 1;

  state_e         state;
  logic [SRW-1:0] sr;
  logic [SRW-1:0] sr_nx;
  logic [K-1:0]   w;
  logic [3:0]     cnt;
  logic [N-1:0]   sym;
  logic           adv;
  logic           accept;
  logic           flush;
  logic           step;
  logic           x;
  logic           last_nx;

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv && (state == ST_DATA);
  assign accept   = in_valid && in_ready;
  assign flush    = adv && (state == ST_FLUSH);
  assign step     = accept || flush;
  assign x        = (state == ST_DATA) && in_data;
  assign last_nx  = flush ? (cnt == 4'd1) : (in_last && (K == 1));

  // sr[0] is the most recent bit, so the window reverses it.
  assign w[K-1]   = x;
  assign sr_nx[0] = x;
  for (genvar j = 0; j < K - 1; j++) begin : g_win
    assign w[K-2-j] = sr[j];
  end
  for (genvar j = 1; j < SRW; j++) begin : g_shift
    assign sr_nx[j] = sr[j-1];
  end

  assign sym = N'(conv_enc_sym(9'(w), 36'(G), K, N));

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      sr        <= '0;
      state     <= ST_DATA;
      cnt       <= '0;
    end else begin
      if (adv) begin
        out_valid <= step;
        out_last  <= step && last_nx;
        if (step)
          out_data <= sym;
      end
      if (step)
        sr <= sr_nx;
      if (accept && in_last && (K > 1)) begin
        state <= ST_FLUSH;
        cnt   <= 4'(K - 1);
      end
      if (flush) begin
        cnt <= cnt - 4'd1;
        if (cnt == 4'd1)
          state <= ST_DATA;
      end
    end
  end

`ifdef CONV_ENC_PUNCT_EN
  logic [N-1:0] mask_nx;

  conv_punct_idx #(
    .N     (N),
    .P     (P),
    .PUNCT (PUNCT)
  ) u_punct (
    .clk      (clk),
    .reset    (reset),
    .step     (step),
    .last     (last_nx),
    .punct_on (punct_on),
    .mask     (mask_nx)
  );

  always_ff @(posedge clk) begin
    if (reset)
      out_mask <= '1;
    else if (adv && step)
      out_mask <= mask_nx;
  end
`endif

endmodule

// File: tb/tb_conv_encoder_param.sv
// Self-checking bench: K=3 default and K=7 instances against a
// window-parity reference model with randomized frames and backpressure.
module tb_conv_encoder_param;
  import conv_enc_pkg::*;

  typedef struct packed {
    logic [1:0] d;
    logic       l;
    logic [1:0] m;
  } exp_t;
  typedef exp_t expq_t[$];

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] iv = '0;
  logic [1:0] idt = '0;
  logic [1:0] il = '0;
  logic [1:0] ir;
  logic [1:0] ov;
  logic [1:0] ordy = 2'b11;
  logic [1:0] ol;
  logic [1:0] od [2];
  logic [1:0] mk [2];
`ifdef CONV_ENC_PUNCT_EN
  logic [1:0] pon = '0;
  logic [1:0] om [2];
  assign mk[0] = om[0];
  assign mk[1] = om[1];
`else
  assign mk[0] = 2'b11;
  assign mk[1] = 2'b11;
`endif

  always #5 clk = ~clk;

  conv_encoder_param dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (iv[0]),
    .in_ready  (ir[0]),
    .in_data   (idt[0]),
    .in_last   (il[0]),
    .out_valid (ov[0]),
    .out_ready (ordy[0]),
    .out_data  (od[0]),
    .out_last  (ol[0])
`ifdef CONV_ENC_PUNCT_EN
    ,
    .punct_on  (pon[0]),
    .out_mask  (om[0])
`endif
  );

  conv_encoder_param #(
    .K (7),
    .N (2),
    .G (G_K7_R12)
  ) dut7 (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (iv[1]),
    .in_ready  (ir[1]),
    .in_data   (idt[1]),
    .in_last   (il[1]),
    .out_valid (ov[1]),
    .out_ready (ordy[1]),
    .out_data  (od[1]),
    .out_last  (ol[1])
`ifdef CONV_ENC_PUNCT_EN
    ,
    .punct_on  (pon[1]),
    .out_mask  (om[1])
`endif
  );

  int         vecs = 0;
  int         errs = 0;
  int         rmode = 0;
  int         popped [2];
  bit         ign [2];
  bit         held [2];
  logic [1:0] hd [2];
  logic       hl [2];
  exp_t       q0[$];
  exp_t       q1[$];

  // Symbol t is the parity of the generator-weighted window of the
  // frame bits followed by K-1 zeros.
  function automatic expq_t model(input int k, input logic [13:0] g,
                                  input bit fr[$], input bit pn);
    expq_t      r;
    bit         x[$];
    exp_t       e;
    bit         p;
    logic [3:0] pm;
    pm = PUNCT_R23;
    x  = fr;
    for (int j = 0; j < k - 1; j++) x.push_back(1'b0);
    for (int t = 0; t < x.size(); t++) begin
      e = '0;
      for (int i = 0; i < 2; i++) begin
        p = 1'b0;
        for (int j = 0; j < k; j++)
          if (t - j >= 0) p = p ^ (x[t-j] & g[i*k+k-1-j]);
        e.d[i] = p;
      end
      e.l = (t == x.size() - 1);
      e.m = pn ? pm[(t%2)*2 +: 2] : 2'b11;
      r.push_back(e);
    end
    return r;
  endfunction

  task automatic cmp(input string nm, input int got, input int want);
    vecs++;
    if (got !== want) begin
      errs++;
      $display("FAIL %s: got %0d want %0d", nm, got, want);
    end
  endtask

  task automatic chk(input int id, input logic v, input logic r,
                     input logic [1:0] d, input logic l,
                     input logic irdy, input logic [1:0] m);
    exp_t e;
    if (held[id]) begin
      vecs++;
      if (d !== hd[id] || l !== hl[id]) begin
        errs++;
        $display("FAIL hold%0d: got %b/%b want %b/%b", id, d, l, hd[id], hl[id]);
      end
    end
    held[id] = 1'b0;
    if (v && !r) begin
      vecs++;
      if (irdy !== 1'b0) begin
        errs++;
        $display("FAIL in_ready_held%0d: got %b want 0", id, irdy);
      end
      held[id] = 1'b1;
      hd[id]   = d;
      hl[id]   = l;
    end
    if (v && r && !ign[id]) begin
      vecs++;
      if ((id == 0) ? (q0.size() == 0) : (q1.size() == 0)) begin
        errs++;
        $display("FAIL extra_sym%0d: got %b want none", id, d);
      end else begin
        e = (id == 0) ? q0.pop_front() : q1.pop_front();
        popped[id]++;
        if (d !== e.d || l !== e.l) begin
          errs++;
          $display("FAIL sym%0d: got d=%b l=%b want d=%b l=%b", id, d, l, e.d, e.l);
        end
`ifdef CONV_ENC_PUNCT_EN
        if (m !== e.m) begin
          errs++;
          $display("FAIL mask%0d: got %b want %b", id, m, e.m);
        end
`else
        if (m !== 2'b11) begin
          errs++;
          $display("FAIL mask%0d: got %b want 11", id, m);
        end
`endif
      end
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      chk(0, ov[0], ordy[0], od[0], ol[0], ir[0], mk[0]);
      chk(1, ov[1], ordy[1], od[1], ol[1], ir[1], mk[1]);
    end else begin
      held[0] = 1'b0;
      held[1] = 1'b0;
    end
  end

  always @(posedge clk) begin
    #1;
    if (rmode == 0)
      ordy = 2'b11;
    else if (rmode == 1)
      ordy = {1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0)};
  end

  task automatic wait_acc(input int id);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ir[id] && n < 500);
    if (!ir[id]) begin
      errs++;
      $display("FAIL accept_timeout%0d: got in_ready=0 want 1", id);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int id, input bit fr[$], input bit pn,
                      input bit gaps);
    expq_t e;
    e = model((id == 0) ? 3 : 7, (id == 0) ? 14'(G_K3_R12) : G_K7_R12, fr, pn);
    iv[id] = 1'b0;
    wait_acc(id);
`ifdef CONV_ENC_PUNCT_EN
    pon[id] = pn;
`endif
    foreach (e[i]) begin
      if (id == 0) q0.push_back(e[i]);
      else q1.push_back(e[i]);
    end
    foreach (fr[b]) begin
      if (gaps) begin
        iv[id] = 1'b0;
        repeat ($urandom_range(0, 2)) begin
          @(posedge clk);
          #1;
        end
      end
      iv[id]  = 1'b1;
      idt[id] = fr[b];
      il[id]  = (b == fr.size() - 1);
      wait_acc(id);
    end
    iv[id] = 1'b0;
    il[id] = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q0.size() != 0 || q1.size() != 0) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (q0.size() != 0 || q1.size() != 0) begin
      errs++;
      $display("FAIL drain: got %0d/%0d pending want 0", q0.size(), q1.size());
      q0.delete();
      q1.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    bit         f[$];
    bit         g[$];
    expq_t      e;
    logic [1:0] t1 [6];
    logic [1:0] t3 [3];
    logic [1:0] imp [7];
    int         n;
    t1  = '{2'b11, 2'b10, 2'b00, 2'b01, 2'b01, 2'b11};
    t3  = '{2'b11, 2'b10, 2'b11};
    imp = '{2'b11, 2'b10, 2'b11, 2'b11, 2'b00, 2'b01, 2'b11};

    // Pin the reference model on hand-computed sequences.
    f = '{1, 0, 1, 1};
    e = model(3, 14'(G_K3_R12), f, 1'b0);
    cmp("pin_t1_len", e.size(), 6);
    for (int i = 0; i < 6; i++) begin
      cmp($sformatf("pin_t1_d%0d", i), int'(e[i].d), int'(t1[i]));
      cmp($sformatf("pin_t1_l%0d", i), int'(e[i].l), (i == 5) ? 1 : 0);
    end
    f = '{1};
    e = model(3, 14'(G_K3_R12), f, 1'b0);
    for (int i = 0; i < 3; i++)
      cmp($sformatf("pin_t3_d%0d", i), int'(e[i].d), int'(t3[i]));
    e = model(7, G_K7_R12, f, 1'b0);
    cmp("pin_imp_len", e.size(), 7);
    for (int i = 0; i < 7; i++)
      cmp($sformatf("pin_imp_d%0d", i), int'(e[i].d), int'(imp[i]));
`ifdef CONV_ENC_PUNCT_EN
    f = '{1, 0, 1, 1};
    e = model(3, 14'(G_K3_R12), f, 1'b1);
    for (int i = 0; i < 6; i++)
      cmp($sformatf("pin_mask%0d", i), int'(e[i].m), (i % 2 == 0) ? 3 : 2);
`endif

    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      cmp($sformatf("rst_valid%0d", i), int'(ov[i]), 0);
      cmp($sformatf("rst_data%0d", i), int'(od[i]), 0);
      cmp($sformatf("rst_last%0d", i), int'(ol[i]), 0);
      cmp($sformatf("rst_in_ready%0d", i), int'(ir[i]), 1);
    end
    @(posedge clk);
    #1;

    f = '{1, 0, 1, 1};
    send(0, f, 1'b0, 1'b0);
    drain();

    // Stall the second symbol for three cycles.
    rmode     = 2;
    ordy      = 2'b11;
    popped[0] = 0;
    fork
      send(0, f, 1'b0, 1'b0);
      begin
        n = 0;
        while (popped[0] < 1 && n < 200) begin
          @(negedge clk);
          #1;
          n++;
        end
        @(posedge clk);
        #1;
        ordy[0] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        ordy[0] = 1'b1;
      end
    join
    drain();
    rmode = 0;

    f = '{1};
    g = '{1, 1};
    send(0, f, 1'b0, 1'b0);
    send(0, g, 1'b0, 1'b0);
    drain();

    // Abort a frame with reset after its second bit.
    ign[0]  = 1'b1;
    iv[0]   = 1'b1;
    idt[0]  = 1'b1;
    il[0]   = 1'b0;
    wait_acc(0);
    wait_acc(0);
    iv[0]   = 1'b0;
    reset   = 1'b1;
    @(posedge clk);
    #1;
    reset   = 1'b0;
    @(negedge clk);
    cmp("abort_valid", int'(ov[0]), 0);
    cmp("abort_in_ready", int'(ir[0]), 1);
    ign[0]  = 1'b0;
    f = '{1};
    send(0, f, 1'b0, 1'b0);
    drain();

    f = {};
    for (int i = 0; i < 10; i++) f.push_back(1'b0);
    send(1, f, 1'b0, 1'b0);
    f = '{1};
    send(1, f, 1'b0, 1'b0);
    drain();

`ifdef CONV_ENC_PUNCT_EN
    f = '{1, 0, 1, 1};
    send(0, f, 1'b1, 1'b0);
    send(0, f, 1'b0, 1'b0);
    drain();
`endif

    rmode = 1;
    for (int it = 0; it < 30; it++) begin
      f = {};
      g = {};
      repeat ($urandom_range(1, 12)) f.push_back(1'($urandom_range(0, 1)));
      repeat ($urandom_range(1, 12)) g.push_back(1'($urandom_range(0, 1)));
      fork
        send(0, f, 1'($urandom_range(0, 1)), 1'b1);
        send(1, g, 1'($urandom_range(0, 1)), 1'b1);
      join
    end
    rmode = 0;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
